// File: rtl/sfif_wb_pkg.sv
// Shared types for the sfif Wishbone master: response status codes, FSM states
// and default bus widths.
package sfif_wb_pkg;

    localparam int unsigned DEF_AW = 18;
    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_SW = 2;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_ERR = 2'b01,
        ST_TMO = 2'b10,
        ST_RTY = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp,
        StGap
    } state_e;

endpackage

// File: rtl/sfif_wbm_timer.sv
// Loadable down-counter with a zero flag; reused for the bus timeout and the
// retry back-off gap, which never run at the same time.
module sfif_wbm_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sfif_wbm.sv
// Command-driven Wishbone master: turns single writes and incrementing read bursts
// into classic Wishbone cycles, with retry back-off, bus timeout and one response per beat.
module sfif_wbm
    import sfif_wb_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned SW        = DEF_SW,
    parameter int unsigned LENW      = 5,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [SW-1:0]   cmd_sel,
    input  logic [LENW-1:0] cmd_len,
    input  logic            cmd_lock,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic            rsp_last,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [SW-1:0]   wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_lock_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int unsigned TMAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = $clog2(MAX_RETRY + 2);
    // Timer reaches zero on the last cycle of the window, hence the -1.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

    state_e          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            cyc_q, cyc_d;
    logic            lock_q, lock_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] beat_q, beat_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    status_e         rsp_status_q, rsp_status_d;
    logic            rsp_last_q, rsp_last_d;

    logic            tmr_load, tmr_dec, tmr_expired;
    logic [TW-1:0]   tmr_val;

    sfif_wbm_timer #(
        .W (TW)
    ) u_timer (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .load_i    (tmr_load),
        .val_i     (tmr_val),
        .dec_i     (tmr_dec),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        cyc_d        = cyc_q;
        lock_d       = lock_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        len_d        = len_q;
        beat_d       = beat_q;
        retry_d      = retry_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        rsp_last_d   = rsp_last_q;
        tmr_load     = 1'b0;
        tmr_val      = TMO_LOAD;
        tmr_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    we_d        = cmd_we;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    sel_d       = cmd_sel;
                    // Writes are always a single beat.
                    len_d       = cmd_we ? '0 : cmd_len;
                    lock_d      = cmd_lock;
                    beat_d      = '0;
                    retry_d     = '0;
                    cyc_d       = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = StBus;
                end
            end
            StBus: begin
                if (wb_ack_i || wb_err_i || (wb_rty_i && retry_q >= RTY_MAX) || tmr_expired) begin
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_dat_d    = '0;
                    rsp_last_d   = 1'b1;
                    state_d      = StResp;
                    if (wb_ack_i) begin
                        rsp_dat_d    = we_q ? '0 : wb_dat_i;
                        rsp_status_d = ST_OK;
                        rsp_last_d   = (beat_q == len_q);
                    end else if (wb_err_i) begin
                        rsp_status_d = ST_ERR;
                    end else if (wb_rty_i) begin
                        rsp_status_d = ST_RTY;
                    end else begin
                        rsp_status_d = ST_TMO;
                    end
                end else if (wb_rty_i) begin
                    cyc_d    = 1'b0;
                    retry_d  = retry_q + 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = StGap;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StGap: begin
                if (tmr_expired) begin
                    cyc_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = StBus;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        lock_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        adr_d    = adr_q + 1'b1;
                        beat_d   = beat_q + 1'b1;
                        retry_d  = '0;
                        cyc_d    = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = StBus;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b0;
            cyc_q        <= 1'b0;
            lock_q       <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            retry_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            cyc_q        <= cyc_d;
            lock_q       <= lock_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            retry_q      <= retry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign rsp_last   = rsp_last_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_lock_o  = lock_q;

endmodule
